alu_serial_ctrl: RTL
====================

Name: alu_serial_ctrl

Overview:
Bit-serial sequencer that drives a 1-bit ALU slice (A, B, c_in, control in; out, carryout back) to perform WIDTH-bit operations LSB-first. It latches a word-level request, presents one operand bit pair per clock to the slice, and feeds the slice's carryout back as the next c_in. It collects the slice's out bits into a result word and reports the final carry. It is the initiator for the slice interface and sits between word-level logic and the 1-bit ALU.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only when busy=0
op  input  3  slice control code, forwarded unchanged
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for bit 0
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result/cout are valid
result  output  WIDTH  assembled result word
cout  output  1  carryout of bit WIDTH-1
slice_a  output  1  to slice A
slice_b  output  1  to slice B
slice_cin  output  1  to slice c_in
slice_control  output  3  to slice control
slice_out  input  1  from slice out
slice_carryout  input  1  from slice carryout

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset (any time, including mid-operation): state=IDLE. busy, done, result, cout, slice_a, slice_b, slice_cin, slice_control, internal shift registers, carry register and bit counter all 0. Any in-flight operation is discarded; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0. On start=1, latch a->a_sh, b->b_sh, op->op_r, cin->carry_r, cnt=0, go to RUN. start=0: stay.
- RUN: busy=1.
  - slice_a=a_sh[0], slice_b=b_sh[0], slice_cin=carry_r, slice_control=op_r. Driven from registers only; no combinational path from start/a/b.
  - Each clock: res_sh <= {slice_out, res_sh[WIDTH-1:1]}; carry_r <= slice_carryout; a_sh and b_sh shift right with 0 fill; cnt++.
  - When cnt==WIDTH-1 at the edge: go to DONE, result <= final shifted res_sh, cout <= slice_carryout.
- DONE: busy=0, done=1 for exactly one cycle. result/cout hold until the next completion or reset.
  - start=1 in DONE: accepted as in IDLE; next state RUN.
  - Otherwise next state IDLE.
- Latency: start sampled at edge k; RUN occupies cycles k+1..k+WIDTH; done high in cycle k+WIDTH+1. Throughput: one operation per WIDTH+1 cycles back-to-back.
- start while busy=1 is ignored; the latched operands and op are unaffected.
- Outside RUN: slice_a/slice_b/slice_cin are 0 and slice_control holds op_r.
- WIDTH=1: a single RUN cycle, then DONE.
- cnt width is clog2(WIDTH)+1; no wrap-around occurs within an operation.

Test Plan:
Bench slice model: control 2 = add (out=A^B^c_in, carryout=majority); control 3 = and (out=A&B, carryout=0).
- Add: op=2, a=8'h5A, b=8'h3C, cin=0, start pulse -> busy for 8 cycles; done in cycle 9 after start edge; result=8'h96, cout=0.
- Add with carry propagation: op=2, a=8'hFF, b=8'h01, cin=0 -> result=8'h00, cout=1. Then a=8'h00, b=8'h00, cin=1 -> result=8'h01, cout=0.
- Logic op and control forwarding: op=3, a=8'hF0, b=8'h3C -> slice_control=3 throughout RUN; result=8'h30, cout=0.
- Ignored start: op=2, a=8'h10, b=8'h01, cin=0; pulse start again at RUN cycle 3 with a=8'hFF -> single done; result=8'h11.
- Back-to-back: hold start high through the DONE cycle with new operands a=8'h01, b=8'h01 -> second RUN begins immediately; second result=8'h02 exactly 9 cycles after first done.
- Reset mid-op: assert reset at RUN cycle 4 -> all outputs 0 immediately (asynchronous), no done pulse. Then a fresh add 8'h03+8'h04 completes with result=8'h07.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice: shifts operands out LSB-first,
// chains the slice carry through a register and assembles the result word.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_control,
  input  logic             slice_out,
  input  logic             slice_carryout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_shift;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every variable gets its hold value first, so no branch can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;

    // Written this way so WIDTH=1 needs no empty part-select.
    res_shift            = res_sh_q >> 1;
    res_shift[WIDTH-1]   = slice_out;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_sh_d = res_shift;
        carry_d  = slice_carryout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          result_d = res_shift;
          cout_d   = slice_carryout;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign result        = result_q;
  assign cout          = cout_q;
  assign slice_a       = busy & a_sh_q[0];
  assign slice_b       = busy & b_sh_q[0];
  assign slice_cin     = busy & carry_q;
  assign slice_control = op_q;

endmodule
